// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver with show-ahead byte FIFO; PS2_RX_TIMEOUT_EN enables mid-frame abort
module ps2_rx_fifo #(
  parameter int FIFO_AW = 4,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               pop,
  input  logic               clr_err,
  output logic [7:0]         rd_data,
  output logic               valid,
  output logic [FIFO_AW:0]   count,
  output logic               int_req,
  output logic               frame_err,
  output logic               overflow
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] ck_s, dt_s;
  logic [FW-1:0] fcnt;
  logic filt, filt_d, strike, d, tmo, frame_ok, push, full, empty, do_pop, do_push, err_set;
  logic [2:0] bitcnt;
  logic [7:0] sh;
  logic par;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0] mem [2 ** FIFO_AW];
  always_comb begin
    d = dt_s[1];
    strike = filt_d & ~filt;
    count = wr_ptr - rd_ptr;
    empty = count == '0;
    full = count == DEPTH;
    valid = !empty;
    rd_data = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
    frame_ok = d && ^{sh, par};
    push = strike && state == STOP && frame_ok;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    err_set = tmo || (strike && ((state == IDLE && d) || (state == STOP && !frame_ok)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
      filt <= 1'b1;
      filt_d <= 1'b1;
      fcnt <= '0;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
      filt_d <= filt;
      fcnt <= (ck_s[1] == filt || fcnt == F_MAX) ? '0 : fcnt + 1'b1;
      filt <= (ck_s[1] != filt && fcnt == F_MAX) ? ck_s[1] : filt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || tmo) begin
      state <= IDLE;
      bitcnt <= '0;
      sh <= '0;
      par <= 1'b0;
    end else if (strike) begin
      case (state)
        IDLE: begin
          state <= d ? IDLE : DATA;
          bitcnt <= '0;
        end
        DATA: begin
          sh <= {d, sh[7:1]};
          bitcnt <= bitcnt + 1'b1;
          state <= bitcnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par <= d;
          state <= STOP;
        end
        STOP: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= sh;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      int_req <= 1'b0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (FIFO_AW + 1)'(do_push);
      rd_ptr <= rd_ptr + (FIFO_AW + 1)'(do_pop);
      int_req <= do_push;
      frame_err <= (frame_err & ~clr_err) | err_set;
      overflow <= (overflow & ~clr_err) | (push & full & ~do_pop);
    end
  end
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk) tcnt <= (reset || state == IDLE || strike || tmo) ? '0 : tcnt + 1'b1;
  always_comb tmo = tcnt == T_MAX;
`else
  always_comb tmo = TIMEOUT_CYC < 0;
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: randomized PS/2 frame stimulus checked against a queue model of the receiver FIFO
module tb_ps2_rx_fifo;
  localparam int FL = 8;
  localparam int TO = 5000;
  localparam int H = 20;
  logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1, pop = 0, clr_err = 0;
  logic [7:0] rd_data;
  logic valid, int_req, frame_err, overflow;
  logic [4:0] count;
  int checks = 0, errors = 0, ip_cnt = 0, wide = 0, lat = 0, cal_lat = 0, m_acc = 0;
  logic int_d = 0, m_err = 0, m_ov = 0;
  logic [7:0] q[$];
  ps2_rx_fifo #(.FIFO_AW(4), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop), .clr_err(clr_err),
    .rd_data(rd_data), .valid(valid), .count(count), .int_req(int_req), .frame_err(frame_err),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    int_d <= int_req;
    if (int_req) ip_cnt <= ip_cnt + 1;
    if (int_req && int_d) wide <= wide + 1;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task send_bits(input logic [10:0] bits, input int n, input int pop_at);
    lat = 0;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H / 2) @(negedge clk);
      ps2_clk = 0;
      for (int k = 1; k <= H; k++) begin
        pop = (i == n - 1) && (k == pop_at);
        @(posedge clk);
        #1;
        if (int_req && lat == 0) lat = k;
        @(negedge clk);
      end
      pop = 0;
      ps2_clk = 1;
      repeat (H / 2) @(negedge clk);
    end
    ps2_data = 1;
  endtask
  task send_frame(input logic [7:0] b, input logic bad_par, input int pop_at);
    logic p;
    p = ~^b ^ bad_par;
    send_bits({1'b1, p, b, 1'b0}, 11, pop_at);
    if (pop_at != 0 && q.size() > 0) void'(q.pop_front());
    if (bad_par) m_err = 1;
    else if (q.size() == 16) m_ov = 1;
    else begin
      q.push_back(b);
      m_acc++;
    end
  endtask
  task pop_byte(output logic [7:0] v);
    v = rd_data;
    pop = 1;
    @(negedge clk);
    pop = 0;
    if (q.size() > 0) void'(q.pop_front());
  endtask
  task clear_err;
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    m_err = 0;
    m_ov = 0;
  endtask
  task test_reset;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({rd_data, valid, count, int_req, frame_err, overflow} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {rd_data, valid, count, int_req, frame_err, overflow});
    end
  endtask
  task test_single;
    logic [7:0] v;
    send_frame(8'h1C, 0, 0);
    cal_lat = lat;
    checks++;
    if (lat < FL + 2 || lat > FL + 6) begin
      errors++;
      $display("FAIL push_latency: got %0d cycles required %0d..%0d", lat, FL + 2, FL + 6);
    end
    checks++;
    if ({valid, rd_data, count} !== {1'b1, 8'h1C, 5'd1} || ip_cnt != m_acc) begin
      errors++;
      $display("FAIL t1_push: got valid=%b data=%h count=%0d irq=%0d required 1 1c 1 %0d", valid, rd_data, count, ip_cnt, m_acc);
    end
    pop_byte(v);
    checks++;
    if ({valid, count, rd_data} !== 14'h0) begin
      errors++;
      $display("FAIL t1_pop: got valid=%b count=%0d data=%h required 0 0 00", valid, count, rd_data);
    end
  endtask
  task test_two;
    logic [7:0] v, e;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = q[0];
      pop_byte(v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL t2_order%0d: got %h required %h", i, v, e);
      end
    end
    checks++;
    if (frame_err !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL t2_status: got err=%b count=%0d required 0 0", frame_err, count);
    end
  endtask
  task test_errors;
    int ip0;
    ip0 = ip_cnt;
    send_frame(8'h1C, 1, 0);
    checks++;
    if (ip_cnt != ip0 || frame_err !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_parity: got irq=%0d err=%b valid=%b required %0d 1 0", ip_cnt, frame_err, valid, ip0);
    end
    clear_err;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL t3_clr: got %b required 0", frame_err);
    end
    send_bits(11'h001, 1, 0);
    m_err = 1;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_start: got %b required 1", frame_err);
    end
    clear_err;
    send_bits({1'b0, ~^8'h3C, 8'h3C, 1'b0}, 11, 0);
    checks++;
    if (frame_err !== 1'b1 || valid !== 1'b0 || ip_cnt != ip0) begin
      errors++;
      $display("FAIL bad_stop: got err=%b valid=%b irq=%0d required 1 0 %0d", frame_err, valid, ip_cnt, ip0);
    end
    clear_err;
  endtask
  task test_overflow;
    logic [7:0] v;
    int ip0;
    ip0 = ip_cnt;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 0, 0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || ip_cnt - ip0 != 16) begin
      errors++;
      $display("FAIL t4_full: got count=%0d ovf=%b irqs=%0d required 16 1 16", count, overflow, ip_cnt - ip0);
    end
    for (int i = 0; i < 16; i++) begin
      pop_byte(v);
      checks++;
      if (v !== 8'(i)) begin
        errors++;
        $display("FAIL t4_pop%0d: got %h required %h", i, v, 8'(i));
      end
    end
    pop_byte(v);
    checks++;
    if (count !== 5'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty: got count=%0d valid=%b required 0 0", count, valid);
    end
    clear_err;
  endtask
  task test_push_pop;
    logic [7:0] v, e;
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 0, 0);
    send_frame(8'($urandom), 0, cal_lat);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL t5_full_pp: got count=%0d ovf=%b required 16 0", count, overflow);
    end
    while (q.size() > 0) begin
      e = q[0];
      pop_byte(v);
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL t5_drain: got %h required %h", v, e);
      end
    end
    send_frame(8'hA5, 0, cal_lat);
    checks++;
    if (count !== 5'd1 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL empty_pp: got count=%0d data=%h required 1 a5", count, rd_data);
    end
    pop_byte(v);
  endtask
  task test_glitch;
    ps2_clk = 0;
    @(negedge clk);
    ps2_clk = 1;
    repeat (30) @(negedge clk);
    ps2_clk = 0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1;
    repeat (30) @(negedge clk);
    send_frame(8'h6B, 0, 0);
    checks++;
    if (frame_err !== 1'b0 || count !== 5'd1 || rd_data !== 8'h6B) begin
      errors++;
      $display("FAIL glitch: got err=%b count=%0d data=%h required 0 1 6b", frame_err, count, rd_data);
    end
  endtask
  task test_random;
    logic [7:0] v, e;
    for (int i = 0; i < 24; i++) begin
      send_frame(8'($urandom), $urandom_range(4) == 0, 0);
      checks++;
      if (count !== 5'(q.size()) || rd_data !== (q.size() ? q[0] : 8'h00) || frame_err !== m_err || overflow !== m_ov) begin
        errors++;
        $display("FAIL rand%0d: got count=%0d data=%h err=%b ovf=%b required %0d %h %b %b", i, count, rd_data, frame_err, overflow, q.size(), q.size() ? q[0] : 8'h00, m_err, m_ov);
      end
      if ($urandom_range(1) == 1) begin
        e = q.size() ? q[0] : 8'h00;
        pop_byte(v);
        checks++;
        if (v !== e) begin
          errors++;
          $display("FAIL rand_pop%0d: got %h required %h", i, v, e);
        end
      end
      if ($urandom_range(5) == 0) clear_err;
    end
    checks++;
    if (ip_cnt != m_acc || wide != 0) begin
      errors++;
      $display("FAIL irq_total: got pulses=%0d wide=%0d required %0d 0", ip_cnt, wide, m_acc);
    end
  endtask
  task test_reset_mid;
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 1, 0);
    send_bits(11'h0A4, 4, 0);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    q.delete();
    m_err = 0;
    m_ov = 0;
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || frame_err !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got count=%0d err=%b valid=%b required 0 0 0", count, frame_err, valid);
    end
    send_frame(8'h5A, 0, 0);
    checks++;
    if (rd_data !== 8'h5A || count !== 5'd1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got data=%h count=%0d err=%b required 5a 1 0", rd_data, count, frame_err);
    end
  endtask
`ifdef PS2_RX_TIMEOUT_EN
  task test_timeout;
    logic [7:0] v;
    pop_byte(v);
    send_bits(11'h0A4, 4, 0);
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL t6_timeout: got err=%b count=%0d required 1 0", frame_err, count);
    end
    clear_err;
    send_frame(8'h1C, 0, 0);
    checks++;
    if (rd_data !== 8'h1C || frame_err !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL t6_next: got data=%h err=%b count=%0d required 1c 0 1", rd_data, frame_err, count);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_single;
    test_two;
    test_errors;
    test_overflow;
    test_push_pop;
    test_glitch;
    test_random;
    test_reset_mid;
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
